// File: rtl/csa8_carry_chain_if.sv
// Beat-level bus between an 8-bit carry-select adder stage, the carry chain
// block and its downstream consumer. 'slave' is the chain block's view.
interface csa8_carry_chain_if;
    // upstream adder beat
    logic [7:0] in_sum;
    logic       in_cout;
    logic       in_valid;
    logic       in_first;
    logic       in_last;
    logic       in_ready;

    // corrected output beat
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       out_carry;
    logic [4:0] out_len;

    // protocol error status
    logic       err;
    logic       err_clr;

    modport slave (
        input  in_sum, in_cout, in_valid, in_first, in_last, out_ready, err_clr,
        output in_ready, out_byte, out_valid, out_last, out_carry, out_len, err
    );

    modport master (
        output in_sum, in_cout, in_valid, in_first, in_last, out_ready, err_clr,
        input  in_ready, out_byte, out_valid, out_last, out_carry, out_len, err
    );
endinterface

// File: rtl/csa8_carry_chain.sv
// Chains byte-wide carry-select adder results into multi-byte words by
// propagating the carry across beats, with a one-entry registered output.
module csa8_carry_chain #(
    parameter int unsigned MAX_BYTES = 16
) (
    input logic               clk,
    input logic               rst,
    csa8_carry_chain_if.slave bus
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_BYTES);

    typedef enum logic {
        IDLE,
        CHAIN
    } state_t;

    state_t     state_q,     state_d;
    logic       carry_q,     carry_d;
    logic [4:0] count_q,     count_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_byte_q,  out_byte_d;
    logic       out_last_q,  out_last_d;
    logic       out_carry_q, out_carry_d;
    logic [4:0] out_len_q,   out_len_d;
    logic       err_q,       err_d;

    logic       in_fire;
    logic       is_start;
    logic       c_in;
    logic [4:0] beat_cnt;
    logic       carry_next;
    logic       overflow;
    logic       word_end;
    logic       err_set;

    // Single-entry output register: accept whenever it is empty or draining.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_len   = out_len_q;
    assign bus.err       = err_q;

    // A stray in_first inside an open word restarts the chain.
    assign is_start   = (state_q == IDLE) || bus.in_first;
    assign c_in       = is_start ? 1'b0 : carry_q;
    assign beat_cnt   = is_start ? 5'd1 : count_q + 5'd1;
    assign carry_next = bus.in_cout || ((bus.in_sum == 8'hFF) && c_in);
    assign overflow   = (beat_cnt == MAX_CNT) && !bus.in_last;
    assign word_end   = bus.in_last || overflow;

    assign err_set = in_fire && (((state_q == IDLE)  && !bus.in_first) ||
                                 ((state_q == CHAIN) &&  bus.in_first) ||
                                 overflow);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a latch.
        state_d     = state_q;
        carry_d     = carry_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        out_len_d   = out_len_q;
        err_d       = err_q;

        if (in_fire) begin
            state_d     = word_end ? IDLE : CHAIN;
            carry_d     = carry_next;
            count_d     = beat_cnt;
            out_valid_d = 1'b1;
            out_byte_d  = bus.in_sum + {7'd0, c_in};
            out_last_d  = word_end;
            out_carry_d = word_end ? carry_next : 1'b0;
            out_len_d   = word_end ? beat_cnt : 5'd0;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Setting wins over a coincident clear so no error is ever lost.
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // NOTE: reset is synchronous and overrides any transfer in the same cycle;
    // all state uses non-blocking assignment so registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            count_q     <= 5'd0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'd0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_len_q   <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            out_len_q   <= out_len_d;
            err_q       <= err_d;
        end
    end

    // A stalled output beat must not change under the consumer.
    property p_hold_stable;
        @(posedge clk) disable iff (rst)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_byte_q) && $stable(out_last_q) &&
             $stable(out_carry_q) && $stable(out_len_q));
    endproperty
    a_hold_stable: assert property (p_hold_stable);

    property p_count_bound;
        @(posedge clk) disable iff (rst) count_q <= MAX_CNT;
    endproperty
    a_count_bound: assert property (p_count_bound);

endmodule

// File: tb/tb_csa8_carry_chain.sv
// Directed bench for csa8_carry_chain: hand-computed vectors for single and
// multi-byte words, backpressure, protocol errors and mid-word reset.
module tb_csa8_carry_chain;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    csa8_carry_chain_if bus ();

    csa8_carry_chain #(.MAX_BYTES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat, let it be taken on the next edge, sample just after.
    task automatic beat(input logic [7:0] sum, input logic cout,
                        input logic first, input logic last);
        bus.in_sum   = sum;
        bus.in_cout  = cout;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] b, input logic l,
                             input logic c, input logic [4:0] n);
        check({tag, ".valid"}, bus.out_valid, 1'b1);
        check({tag, ".byte"},  bus.out_byte,  b);
        check({tag, ".last"},  bus.out_last,  l);
        check({tag, ".carry"}, bus.out_carry, c);
        check({tag, ".len"},   bus.out_len,   n);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.in_sum    = 8'h55;
        bus.in_cout   = 1'b1;
        bus.in_first  = 1'b1;
        bus.in_last   = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;

        // Reset with a beat presented: beat dropped, in_ready high.
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", bus.in_ready, 1'b1);
        check("rst.valid",    bus.out_valid, 1'b0);
        check("rst.byte",     bus.out_byte, 8'h00);
        check("rst.last",     bus.out_last, 1'b0);
        check("rst.len",      bus.out_len, 5'd0);
        check("rst.err",      bus.err, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        idle();

        // Single byte word.
        beat(8'h34, 1'b0, 1'b1, 1'b1);
        check_out("single", 8'h34, 1'b1, 1'b0, 5'd1);
        check("single.err", bus.err, 1'b0);

        // 0xFFFF + 0xFFFF, back to back.
        beat(8'hFE, 1'b1, 1'b1, 1'b0);
        check_out("ffff.b0", 8'hFE, 1'b0, 1'b0, 5'd0);
        beat(8'hFE, 1'b1, 1'b0, 1'b1);
        check_out("ffff.b1", 8'hFF, 1'b1, 1'b1, 5'd2);

        // Carry rippling through a 0xFF sum byte.
        beat(8'h00, 1'b1, 1'b1, 1'b0);
        check_out("ripple.b0", 8'h00, 1'b0, 1'b0, 5'd0);
        beat(8'hFF, 1'b0, 1'b0, 1'b1);
        check_out("ripple.b1", 8'h00, 1'b1, 1'b1, 5'd2);
        check("ripple.err", bus.err, 1'b0);
        idle();
        check("drain.valid", bus.out_valid, 1'b0);

        // Backpressure: pending second beat waits, output held.
        bus.out_ready = 1'b0;
        beat(8'h11, 1'b0, 1'b1, 1'b0);
        check_out("bp.b0", 8'h11, 1'b0, 1'b0, 5'd0);
        bus.in_sum   = 8'h22;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp.in_ready", bus.in_ready, 1'b0);
            check_out("bp.hold", 8'h11, 1'b0, 1'b0, 5'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        check_out("bp.b1", 8'h22, 1'b1, 1'b0, 5'd2);
        idle();

        // in_first inside an open word: error, carry discarded.
        beat(8'h10, 1'b1, 1'b1, 1'b0);
        check("restart.err0", bus.err, 1'b0);
        beat(8'h05, 1'b0, 1'b1, 1'b1);
        check_out("restart", 8'h05, 1'b1, 1'b0, 5'd1);
        check("restart.err", bus.err, 1'b1);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        check("clr.err", bus.err, 1'b0);

        // Word begun without in_first from IDLE.
        beat(8'h07, 1'b0, 1'b0, 1'b1);
        check_out("nofirst", 8'h07, 1'b1, 1'b0, 5'd1);
        check("nofirst.err", bus.err, 1'b1);
        idle();
        check("sticky.err", bus.err, 1'b1);

        // Clear coinciding with a new error keeps err set.
        bus.err_clr = 1'b1;
        beat(8'h08, 1'b0, 1'b0, 1'b1);
        bus.err_clr = 1'b0;
        check("clrset.err", bus.err, 1'b1);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        check("clr2.err", bus.err, 1'b0);

        // Sixteen beats without in_last: beat 16 forced to end the word.
        for (int i = 1; i <= 16; i++) begin
            beat(8'(i), 1'b0, (i == 1), 1'b0);
            if (i == 15) begin
                check_out("ovf.b15", 8'h0F, 1'b0, 1'b0, 5'd0);
                check("ovf.b15.err", bus.err, 1'b0);
            end
        end
        check_out("ovf.b16", 8'h10, 1'b1, 1'b0, 5'd16);
        check("ovf.err", bus.err, 1'b1);
        beat(8'h20, 1'b0, 1'b1, 1'b1);
        check_out("ovf.next", 8'h20, 1'b1, 1'b0, 5'd1);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        check("clr3.err", bus.err, 1'b0);

        // Reset mid-word after a carry-producing beat.
        beat(8'h40, 1'b1, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst.valid", bus.out_valid, 1'b0);
        check("mrst.byte",  bus.out_byte, 8'h00);
        check("mrst.carry", bus.out_carry, 1'b0);
        check("mrst.len",   bus.out_len, 5'd0);
        beat(8'h10, 1'b0, 1'b1, 1'b1);
        check_out("mrst.next", 8'h10, 1'b1, 1'b0, 5'd1);
        check("mrst.err", bus.err, 1'b0);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
